// File: rtl/axi_aw_buffer_pkg.sv
// Shared AXI bus definitions for the AW write-address buffer: payload layout and width helpers.
`ifndef BUS_ID_W
`define BUS_ID_W 4
`endif
`ifndef PADDR
`define PADDR 32
`endif

package axi_aw_buffer_pkg;

    localparam int BUS_ID_W   = `BUS_ID_W;
    localparam int BUS_ADDR_W = `PADDR;

    // Everything in AW except id and address: len, size, burst, lock, cache, prot, qos, region.
    localparam int AW_CTRL_W = 29;

    typedef struct packed {
        logic [7:0] awlen;
        logic [2:0] awsize;
        logic [1:0] awburst;
        logic       awlock;
        logic [3:0] awcache;
        logic [2:0] awprot;
        logic [3:0] awqos;
        logic [3:0] awregion;
    } aw_ctrl_t;

    typedef struct packed {
        logic [BUS_ID_W-1:0]   awid;
        logic [BUS_ADDR_W-1:0] awaddr;
        aw_ctrl_t              ctrl;
    } aw_payload_t;

    localparam int AW_PAYLOAD_W = $bits(aw_payload_t);

    function automatic int aw_width(input int id_w, input int addr_w);
        return id_w + addr_w + AW_CTRL_W;
    endfunction

endpackage

// File: rtl/bus_fifo.sv
// Generic in-order payload FIFO with extra-MSB pointers; storage array is intentionally not reset.
module bus_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/axi_aw_buffer.sv
// AW channel buffer: queues write addresses and throttles issue on the count of writes awaiting B.
module axi_aw_buffer
    import axi_aw_buffer_pkg::*;
#(
    parameter int ID_W      = `BUS_ID_W,
    parameter int ADDR_W    = `PADDR,
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 8
) (
    input  logic                           clk_i,
    input  logic                           arst_i,

    input  logic [ID_W-1:0]                s_awid,
    input  logic [ADDR_W-1:0]              s_awaddr,
    input  logic [7:0]                     s_awlen,
    input  logic [2:0]                     s_awsize,
    input  logic [1:0]                     s_awburst,
    input  logic                           s_awlock,
    input  logic [3:0]                     s_awcache,
    input  logic [2:0]                     s_awprot,
    input  logic [3:0]                     s_awqos,
    input  logic [3:0]                     s_awregion,
    input  logic                           s_awvalid,
    output logic                           s_awready,

    output logic [ID_W-1:0]                m_awid,
    output logic [ADDR_W-1:0]              m_awaddr,
    output logic [7:0]                     m_awlen,
    output logic [2:0]                     m_awsize,
    output logic [1:0]                     m_awburst,
    output logic                           m_awlock,
    output logic [3:0]                     m_awcache,
    output logic [2:0]                     m_awprot,
    output logic [3:0]                     m_awqos,
    output logic [3:0]                     m_awregion,
    output logic                           m_awvalid,
    input  logic                           m_awready,

    input  logic                           b_valid_i,
    input  logic                           b_ready_i,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
    output logic                           err_o
);

    localparam int PW = aw_width(ID_W, ADDR_W);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTST);

    aw_ctrl_t      s_ctrl;
    aw_ctrl_t      m_ctrl;
    logic [PW-1:0] s_payload;
    logic [PW-1:0] m_payload;
    logic          fifo_full;
    logic          fifo_empty;
    logic          aw_push;
    logic          aw_hs;
    logic          b_hs;
    logic [OW-1:0] outst;
    logic          err;

    always_comb begin
        s_ctrl          = '0;
        s_ctrl.awlen    = s_awlen;
        s_ctrl.awsize   = s_awsize;
        s_ctrl.awburst  = s_awburst;
        s_ctrl.awlock   = s_awlock;
        s_ctrl.awcache  = s_awcache;
        s_ctrl.awprot   = s_awprot;
        s_ctrl.awqos    = s_awqos;
        s_ctrl.awregion = s_awregion;
    end

    assign s_payload = {s_awid, s_awaddr, s_ctrl};
    assign {m_awid, m_awaddr, m_ctrl} = m_payload;

    assign m_awlen    = m_ctrl.awlen;
    assign m_awsize   = m_ctrl.awsize;
    assign m_awburst  = m_ctrl.awburst;
    assign m_awlock   = m_ctrl.awlock;
    assign m_awcache  = m_ctrl.awcache;
    assign m_awprot   = m_ctrl.awprot;
    assign m_awqos    = m_ctrl.awqos;
    assign m_awregion = m_ctrl.awregion;

    // Ready depends only on registered fullness, so a same-cycle pop never frees a slot.
    assign s_awready = !fifo_full && !arst_i;
    assign m_awvalid = !fifo_empty && (outst < MAX_CNT) && !arst_i;
    assign aw_push   = s_awvalid && s_awready;
    assign aw_hs     = m_awvalid && m_awready;
    assign b_hs      = b_valid_i && b_ready_i;

    bus_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .push    (aw_push),
        .wr_data (s_payload),
        .pop     (aw_hs),
        .rd_data (m_payload),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            outst <= '0;
            err   <= 1'b0;
        end else begin
            case ({aw_hs, b_hs})
                2'b10:   outst <= outst + 1'b1;
                2'b01: begin
                    // A response with nothing issued is a protocol error; the count stays at zero.
                    if (outst == '0) err   <= 1'b1;
                    else             outst <= outst - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign outst_o = outst;
    assign err_o   = err;

endmodule
